// File: rtl/dm_ctrl_pkg.sv
// Shared definitions for the data-memory port arbiter and its byte-enable generator.
package dm_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_DMA  = 2'b10
  } owner_e;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_HI   = 4'b1100;
  localparam logic [3:0] BE_LO   = 4'b0011;
  localparam logic [3:0] BE_NONE = 4'b0000;

  localparam logic [3:0] BURST_CNT_MAX = 4'hF;

  // Counter step that sticks at the top value instead of wrapping.
  function automatic logic [3:0] sat_inc(input logic [3:0] value);
    return (value == BURST_CNT_MAX) ? BURST_CNT_MAX : value + 4'd1;
  endfunction

endpackage

// File: rtl/dm_be_gen.sv
// Byte-enable and alignment decode from access size and the two low address bits.
module dm_be_gen
  import dm_ctrl_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] be,
  output logic       aligned
);

  logic [3:0] lane_hit;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_hit[gi] = (addr_lo == 2'(gi));
  end

  // A misaligned access yields no enables so nothing downstream can write.
  always_comb begin
    be      = BE_NONE;
    aligned = 1'b0;
    case (size)
      SZ_BYTE: begin
        aligned = 1'b1;
        be      = lane_hit;
      end
      SZ_HALF: begin
        aligned = ~addr_lo[0];
        if (~addr_lo[0]) begin
          be = addr_lo[1] ? BE_HI : BE_LO;
        end
      end
      SZ_WORD: begin
        aligned = (addr_lo == 2'b00);
        if (addr_lo == 2'b00) begin
          be = BE_WORD;
        end
      end
      default: begin
        be      = BE_NONE;
        aligned = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Arbitrates the single data-memory port between the CPU MEM stage and a DMA master.
// Build option DM_LOAD_EXT_EN: lane-select and sign/zero-extend CPU loads.
module dm_port_arbiter
  import dm_ctrl_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic              cpu_unsigned,
  output logic              cpu_stall,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_aerr,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [31:0]       dma_wdata,
  output logic              dma_gnt,
  output logic [31:0]       dma_rdata,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  output logic              dm_we,
  output logic [3:0]        dm_be,
  input  logic [31:0]       dm_rdata
);

  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  owner_e     owner_reg, owner_next;
  owner_e     last_gnt_reg, last_gnt_next;
  logic [3:0] burst_cnt_reg, burst_cnt_next;
  logic       cpu_aerr_reg;

  logic       cpu_gnt;
  logic       dma_gnt_int;
  logic [3:0] cpu_be;
  logic       cpu_aligned;
  logic [31:0] load_word;

  dm_be_gen u_be_gen (
    .size    (cpu_size),
    .addr_lo (cpu_addr[1:0]),
    .be      (cpu_be),
    .aligned (cpu_aligned)
  );

  // Grants are suppressed while reset is held so the memory sees an idle port.
  always_comb begin
    cpu_gnt     = 1'b0;
    dma_gnt_int = 1'b0;
    if (!reset) begin
      if (cpu_req && dma_req) begin
        if (owner_reg == OWN_DMA) begin
          if (burst_cnt_reg < BURST_LAST) begin
            dma_gnt_int = 1'b1;
          end else begin
            cpu_gnt = 1'b1;
          end
        end else if (last_gnt_reg == OWN_DMA) begin
          cpu_gnt = 1'b1;
        end else begin
          dma_gnt_int = 1'b1;
        end
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (dma_req) begin
        dma_gnt_int = 1'b1;
      end
    end
  end

  // The burst counter only advances on back-to-back DMA cycles; a fresh
  // DMA ownership starts counting from zero.
  always_comb begin
    owner_next     = OWN_IDLE;
    last_gnt_next  = last_gnt_reg;
    burst_cnt_next = 4'd0;
    if (cpu_gnt) begin
      owner_next    = OWN_CPU;
      last_gnt_next = OWN_CPU;
    end else if (dma_gnt_int) begin
      owner_next    = OWN_DMA;
      last_gnt_next = OWN_DMA;
      if (owner_reg == OWN_DMA) begin
        burst_cnt_next = sat_inc(burst_cnt_reg);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_reg     <= OWN_IDLE;
      last_gnt_reg  <= OWN_DMA;
      burst_cnt_reg <= 4'd0;
      cpu_aerr_reg  <= 1'b0;
    end else begin
      owner_reg     <= owner_next;
      last_gnt_reg  <= last_gnt_next;
      burst_cnt_reg <= burst_cnt_next;
      cpu_aerr_reg  <= cpu_gnt & ~cpu_aligned;
    end
  end

  always_comb begin
    dm_addr  = '0;
    dm_wdata = '0;
    dm_we    = 1'b0;
    dm_be    = BE_NONE;
    if (cpu_gnt) begin
      dm_addr  = {cpu_addr[ADDR_W-1:2], 2'b00};
      dm_wdata = cpu_wdata;
      dm_we    = cpu_we & cpu_aligned;
      dm_be    = cpu_be;
    end else if (dma_gnt_int) begin
      dm_addr  = {dma_addr[ADDR_W-1:2], 2'b00};
      dm_wdata = dma_wdata;
      dm_we    = dma_we;
      dm_be    = BE_WORD;
    end
  end

`ifdef DM_LOAD_EXT_EN
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Misaligned loads fall through to the raw word.
  always_comb begin
    case (cpu_addr[1:0])
      2'd0:    ld_byte = dm_rdata[7:0];
      2'd1:    ld_byte = dm_rdata[15:8];
      2'd2:    ld_byte = dm_rdata[23:16];
      default: ld_byte = dm_rdata[31:24];
    endcase
    ld_half   = cpu_addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    load_word = dm_rdata;
    if (cpu_aligned) begin
      case (cpu_size)
        SZ_BYTE: load_word = {{24{~cpu_unsigned & ld_byte[7]}}, ld_byte};
        SZ_HALF: load_word = {{16{~cpu_unsigned & ld_half[15]}}, ld_half};
        default: load_word = dm_rdata;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^dma_addr[1:0];
`else
  assign load_word = dm_rdata;

  logic unused_bits;
  assign unused_bits = ^{cpu_unsigned, dma_addr[1:0]};
`endif

  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign cpu_rdata = cpu_gnt ? load_word : 32'd0;
  assign cpu_aerr  = cpu_aerr_reg;
  assign dma_gnt   = dma_gnt_int;
  assign dma_rdata = dma_gnt_int ? dm_rdata : 32'd0;

endmodule
